axi_master_burst_gen: RTL
=========================

// Module: axi_master_burst_gen
// PURPOSE
// - Directed AXI4 master traffic generator. It drives the slave-side AXI interface of a memory-backed slave model, either directly or through the interconnect.
// - Accepts one command at a time: a single write burst or a single read burst. Write data follows a seeded pattern; read data is checked against the same pattern.
// - Reports completion status and mismatch count to the UVM/directed bench. Only one transaction is outstanding at any time.
// PARAMETERS
// ID_VAL          4'h0   value driven on awid/arid
// TIMEOUT_CYCLES  1024   max cycles spent waiting in any single handshake state before abort
// PORTS
// ACLK          in   1   clock, all logic on rising edge
// ARESETN       in   1   asynchronous active-low reset
// cmd_valid     in   1   command request
// cmd_ready     out  1   high only in IDLE
// cmd_write     in   1   1=write burst, 0=read burst
// cmd_addr      in   32  start address (word aligned)
// cmd_len       in   8   AxLEN (beats-1)
// cmd_burst     in   2   00 FIXED, 01 INCR, 10 WRAP
// cmd_seed      in   32  data pattern seed
// done          out  1   one-cycle pulse at end of transaction
// done_resp     out  2   BRESP, or the worst RRESP seen (largest value)
// done_err      out  1   mismatch | rlast error | timeout | illegal command
// done_timeout  out  1   abort was caused by timeout
// mismatch_cnt  out  16  read beats with rdata != expected; saturates at 16'hFFFF
// awid/awaddr/awlen/awsize/awburst/awvalid   out 4/32/8/3/2/1; awready in 1
// wdata/wstrb/wlast/wvalid                   out 32/4/1/1;     wready  in 1
// bid/bresp/bvalid in 4/2/1;                                    bready  out 1
// arid/araddr/arlen/arsize/arburst/arvalid   out 4/32/8/3/2/1; arready in 1
// rid/rdata/rresp/rlast/rvalid in 4/32/2/1/1;                   rready  out 1
// BEHAVIOUR
// - Reset (async): state=IDLE; all valid/ready outputs, done, done_err and done_timeout = 0; mismatch_cnt=0, done_resp=0; all address/data outputs = 0.
// - Reset mid-burst: valids drop immediately and the transaction is discarded. No done pulse is produced.
// - Constant outputs: awsize=arsize=3'b010; wstrb=4'hF; awid=arid=ID_VAL.
// - Expected/written data for beat k = cmd_seed + k, computed modulo 2^32. The beat counter is 8 bits and restarts at 0 for every transaction.
// - FSM: IDLE, AW, W, B, AR, R, DONE.
//   IDLE: cmd_ready=1. On cmd_valid, latch the command and clear mismatch_cnt, done_resp and flags.
//     WRAP with cmd_len not in {1,3,7,15}, or burst=2'b11: go to DONE with done_err=1 and no bus activity.
//     Otherwise go to AW (write) or AR (read).
//   AW: awvalid=1 from the cycle after acceptance, with address and control stable. Hold until awready, then go to W.
//     W is never issued before the AW handshake.
//   W: wvalid=1, wdata=seed+k, wlast=(k==len). Advance k on wvalid&wready.
//     On the handshake with wlast: wvalid=0 and go to B.
//   B: bready=1. On bvalid: capture bresp into done_resp, go to DONE.
//   AR: arvalid held until arready, then go to R.
//   R: rready=1 continuously. On each rvalid beat:
//     compare rdata to seed+k and increment mismatch_cnt on inequality;
//     done_resp = max(done_resp, rresp).
//     rlast at k!=len, or no rlast at k==len: set done_err. The burst ends on rlast, or on beat len if rlast never comes (remaining beats are ignored).
//   DONE: done=1 for exactly one cycle, then return to IDLE. Status outputs hold until the next command is accepted.
// - Timeout: a 16-bit counter resets on each state entry and counts while a handshake is pending in AW/W/B/AR/R.
//   On reaching TIMEOUT_CYCLES: drop all valid/ready outputs, set done_timeout and done_err, go to DONE.
// - done_err also ORs in (mismatch_cnt != 0) at DONE.
// - Throughput: zero-wait slave gives AW 1 cycle, W len+1 cycles, B 1 cycle. No bubbles between W beats.
// TESTING
// - Write INCR addr 0x100, len 3, seed 0xA0: wdata A0,A1,A2,A3 with wlast on beat 3; bresp 0 -> done, err=0.
// - Read back the same command: rdata A0..A3 -> mismatch_cnt=0, done_err=0, done_resp=0.
// - Read with seed 0xB0 over the same data -> mismatch_cnt=4, done_err=1.
// - WRAP addr 0x10C, len 3, seed 0: slave memory holds 0x100=1, 0x104=2, 0x108=3, 0x10C=0; readback -> mismatch_cnt=0.
// - Slave awready tied 0, TIMEOUT_CYCLES=16 -> awvalid drops after 16 cycles; done_timeout=1, done_err=1.
// - WRAP len 2 -> done within 2 cycles, done_err=1, awvalid/arvalid never asserted; ARESETN pulsed mid-W -> wvalid=0 at once.

Source files
------------

// File: rtl/axi_master_burst_gen.sv
// rtl/axi_master_burst_gen.sv - directed AXI4 master issuing one seeded write or read burst per command
module axi_master_burst_gen #(
    parameter logic [3:0] ID_VAL         = 4'h0,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [1:0]  cmd_burst,
    input  logic [31:0] cmd_seed,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic        done_err,
    output logic        done_timeout,
    output logic [15:0] mismatch_cnt,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state, state_nxt;
    logic [31:0] addr_q, seed_q, exp_data;
    logic [7:0]  len_q, beat;
    logic [1:0]  burst_q;
    logic [15:0] tmo_cnt;
    logic        err_q, accept, illegal, pending, tmo_hit, beat_hs, last_beat;
    logic        unused_ids;

    assign unused_ids = ^{bid, rid};
    assign exp_data   = seed_q + {24'd0, beat};
    assign last_beat  = (beat == len_q);
    assign accept     = (state == S_IDLE) && cmd_valid;
    assign illegal    = (cmd_burst == 2'b11) ||
                        ((cmd_burst == 2'b10) && !(cmd_len == 8'd1 || cmd_len == 8'd3 ||
                                                   cmd_len == 8'd7 || cmd_len == 8'd15));
    // Abort only once the counter has run the full budget, so valid stays up TIMEOUT_CYCLES cycles
    assign tmo_hit    = (state inside {S_AW, S_W, S_B, S_AR, S_R}) && (tmo_cnt == TMO_LIMIT);

    assign awid = ID_VAL;          assign arid = ID_VAL;
    assign awsize = 3'b010;        assign arsize = 3'b010;
    assign wstrb = 4'hF;
    assign awaddr = addr_q;        assign araddr = addr_q;
    assign awlen = len_q;          assign arlen = len_q;
    assign awburst = burst_q;      assign arburst = burst_q;
    assign wdata = exp_data;
    assign wlast = (state == S_W) && last_beat;
    assign done = (state == S_DONE);
    assign done_err = err_q || (mismatch_cnt != 16'd0);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        pending   = 1'b0;
        beat_hs   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = illegal ? S_DONE : (cmd_write ? S_AW : S_AR);
            end
            S_AW: begin
                awvalid = 1'b1;
                pending = !awready;
                if (awready) state_nxt = S_W;
            end
            S_W: begin
                wvalid  = 1'b1;
                pending = !wready;
                beat_hs = wready;
                if (wready && last_beat) state_nxt = S_B;
            end
            S_B: begin
                bready  = 1'b1;
                pending = !bvalid;
                if (bvalid) state_nxt = S_DONE;
            end
            S_AR: begin
                arvalid = 1'b1;
                pending = !arready;
                if (arready) state_nxt = S_R;
            end
            S_R: begin
                rready  = 1'b1;
                pending = !rvalid;
                beat_hs = rvalid;
                if (rvalid && (rlast || last_beat)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = S_DONE;
            awvalid   = 1'b0;
            wvalid    = 1'b0;
            bready    = 1'b0;
            arvalid   = 1'b0;
            rready    = 1'b0;
            beat_hs   = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_q       <= '0;
            seed_q       <= '0;
            len_q        <= '0;
            burst_q      <= '0;
            beat         <= '0;
            tmo_cnt      <= '0;
            err_q        <= 1'b0;
            done_timeout <= 1'b0;
            done_resp    <= '0;
            mismatch_cnt <= '0;
        end else begin
            if (state_nxt != state) tmo_cnt <= '0;
            else if (pending)       tmo_cnt <= tmo_cnt + 16'd1;

            if (accept) begin
                addr_q       <= cmd_addr;
                seed_q       <= cmd_seed;
                len_q        <= cmd_len;
                burst_q      <= cmd_burst;
                beat         <= '0;
                err_q        <= illegal;
                done_timeout <= 1'b0;
                done_resp    <= '0;
                mismatch_cnt <= '0;
            end

            if (tmo_hit) begin
                err_q        <= 1'b1;
                done_timeout <= 1'b1;
            end

            if (state == S_B && bready && bvalid) done_resp <= bresp;

            if (beat_hs && !last_beat && !(state == S_R && rlast)) beat <= beat + 8'd1;

            if (state == S_R && beat_hs) begin
                if (rdata != exp_data && mismatch_cnt != 16'hFFFF)
                    mismatch_cnt <= mismatch_cnt + 16'd1;
                if (rresp > done_resp) done_resp <= rresp;
                // rlast must coincide exactly with the final beat in either direction
                if (rlast != last_beat) err_q <= 1'b1;
            end
        end
    end
endmodule
